// File: rtl/pool_upsample_tx.sv
// Nearest-neighbour 2x upsampler for 3x3x3 pooled maps: two-entry ping-pong map store,
// streamed out as a 6x6 raster, one 3-channel pixel per valid/ready beat.
module pool_upsample_tx #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [27*DW-1:0] pool_lin,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [3*DW-1:0] out_pix,
  output logic [2:0]      out_row,
  output logic [2:0]      out_col,
  output logic            out_last
);

  localparam logic [2:0] LAST_IDX = 3'd5;

  logic [27*DW-1:0] map_buf [2];
  logic             wp;
  logic             rp;
  logic [1:0]       cnt;
  logic [2:0]       row;
  logic [2:0]       col;

  logic accept;
  logic beat;
  logic at_end;
  logic last_beat;

  assign in_rdy    = (cnt != 2'd2);
  assign out_vld   = (cnt != 2'd0);
  assign accept    = in_vld && in_rdy;
  assign beat      = out_vld && out_rdy;
  assign at_end    = (row == LAST_IDX) && (col == LAST_IDX);
  assign last_beat = beat && at_end;

  // NOTE: the map store carries no reset; its contents are only ever read after a write.
  always_ff @(posedge clk) begin
    if (accept) map_buf[wp] <= pool_lin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
      row <= 3'd0;
      col <= 3'd0;
    end else begin
      if (accept) wp <= ~wp;

      case ({accept, last_beat})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase

      // With one map held, a simultaneous accept fills the free slot that rp moves to here.
      if (beat) begin
        if (at_end) begin
          row <= 3'd0;
          col <= 3'd0;
          rp  <= ~rp;
        end else if (col == LAST_IDX) begin
          col <= 3'd0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

  // Output pixel (R,C) replicates source element (R>>1, C>>1) of every channel.
  logic [3:0]       src_idx;
  logic [27*DW-1:0] rd_map;

  always_comb begin
    src_idx = ({2'b00, row[2:1]} * 4'd3) + {2'b00, col[2:1]};
    rd_map  = map_buf[rp];
    out_pix = '0;
    if (out_vld) begin
      for (int ch = 0; ch < 3; ch++) begin
        out_pix[ch*DW +: DW] = rd_map[(ch*9 + int'(src_idx))*DW +: DW];
      end
    end
  end

  assign out_row  = out_vld ? row : 3'd0;
  assign out_col  = out_vld ? col : 3'd0;
  assign out_last = out_vld && at_end;

endmodule
